digit_counter_ctl: RTL and testbench
====================================

DIGIT_COUNTER_CTL -- requirements
Module: digit_counter_ctl

Interface
REQ-001 Parameter: WIDTH, 32, number of counter digits (dual-rail sum bus is 2*WIDTH).
REQ-002 Parameter: SYNC_STAGES, 2, flops in the ack synchronizer (minimum 2).
REQ-003 Parameter: TIMEOUT, 1023, cycles allowed per handshake phase before error.
REQ-004 Port: clk  in  1  sole clock; all state is on its rising edge.
REQ-005 Port: init_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: start  in  1  one-cycle request to run a burst of increments; ignored while busy=1.
REQ-007 Port: target  in  32  number of increment wavefronts for the burst, sampled when start is accepted.
REQ-008 Port: abort  in  1  stop the burst after a clean NULL return.
REQ-009 Port: cin  out  2  dual-rail carry-in to digit 0: 00 NULL, 10 DATA1; 01 and 11 are never driven.
REQ-010 Port: ack  in  1  asynchronous completion from the counter: 1 = requests DATA, 0 = requests NULL.
REQ-011 Port: sum_dr  in  2*WIDTH  dual-rail sum digits; digit k is {sum_dr[2k+1], sum_dr[2k]}.
REQ-012 Port: busy  out  1  burst in progress (any state other than IDLE).
REQ-013 Port: done  out  1  one-cycle pulse when the burst completes.
REQ-014 Port: err  out  1  sticky error flag.
REQ-015 Port: issued  out  32  count of completed DATA/NULL cycles in the current burst.
REQ-016 Port: value  out  WIDTH  last complete sum decoded to binary (digit k = sum_dr[2k+1]).
REQ-017 Port: value_valid  out  1  value holds a decoded sum from the current burst.

Function
REQ-018 The ack input shall pass through SYNC_STAGES flops; ack_s denotes the synchronized value, and all decisions shall use ack_s only.
REQ-019 The states shall be: IDLE, WAIT_RFD (ack_s=1 awaited), DATA (cin=10, ack_s=0 awaited), NULL (cin=00, ack_s=1 awaited), DRAIN, DONE, and ERR.
REQ-020 In IDLE, start with target!=0 shall clear issued and value_valid and enter WAIT_RFD; start with target=0 shall enter DONE directly, with no wavefront.
REQ-021 In WAIT_RFD, ack_s=1 shall enter DATA, with cin=10 registered on the next edge.
REQ-022 In DATA, ack_s=0 shall enter NULL, with cin=00 on the next edge.
REQ-023 In NULL, ack_s=1 shall increment issued; if issued+1==target, the machine shall enter DONE, otherwise DATA.
REQ-024 The DONE state shall last exactly one cycle, assert done, and return to IDLE.
REQ-025 While in DATA, when every digit of sum_dr is one-hot (01 or 10), the block shall latch value and set value_valid.
REQ-026 Any digit equal to 11 shall set err and enter ERR, with cin=00.
REQ-027 Abort in WAIT_RFD, DATA or NULL shall enter DRAIN; DRAIN shall drive cin=00, wait for ack_s=1, then enter IDLE without a done pulse.
REQ-028 Abort and start in the same cycle in IDLE: abort shall win and start shall be dropped.
REQ-029 ERR shall hold cin=00 and busy=1; abort shall clear err and enter DRAIN.
REQ-030 issued shall saturate at 32'hFFFFFFFF and shall not wrap.

Reset
REQ-031 While init_n=0: state=IDLE, cin=00, busy=0, done=0, err=0, issued=0, value=0, value_valid=0, synchronizer flops=0.
REQ-032 Reset asserted mid-burst shall abandon the burst immediately with cin=00; the counter shall be reinitialized externally.

Configuration
REQ-033 Macro DIGIT_COUNTER_CTL_WATCHDOG_EN: when defined, a phase counter shall be cleared on every state change, and reaching TIMEOUT in WAIT_RFD, DATA, NULL or DRAIN shall set err and enter ERR.
REQ-034 When DIGIT_COUNTER_CTL_WATCHDOG_EN is not defined, no timeout logic shall exist and the phases shall wait indefinitely.

Structure
REQ-035 Package ncl_ctl_pkg shall hold the state enum and the dual-rail constants DR_NULL=2'b00, DR_D0=2'b01, DR_D1=2'b10, DR_ILL=2'b11.
REQ-036 Sub-module dr_decode shall be combinational and map sum_dr to value, complete and illegal; the synchronizer shall stay inline.

Verification
REQ-037 The bench shall cover these directed scenarios:
- target=5 with a behavioural counter model (ack toggles 3 cycles after cin): exactly 5 DATA wavefronts, issued=5, done pulse once, value=5.
- start with target=0: done on the next cycle, cin stays 00, issued=0.
- abort during the 3rd DATA of target=10: cin→00, DRAIN until ack=1, IDLE, no done, issued=2.
- sum_dr digit 7 forced to 11 during DATA: err=1, state ERR, cin=00; abort then clears err.
- with the watchdog enabled and TIMEOUT=16, ack held at 0 after cin=10: err sets 16 cycles after entering DATA; without the macro, no err after 1000 cycles.
- init_n pulsed low mid-burst at issued=3: all outputs return to their reset values asynchronously, and the next start runs cleanly.

Source files
------------

// File: rtl/ncl_ctl_pkg.sv
// rtl/ncl_ctl_pkg.sv - shared state encoding and dual-rail constants for the NCL counter controller
package ncl_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RFD,
    DATA,
    NULL,
    DRAIN,
    DONE,
    ERR
  } ctl_state_e;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_D0   = 2'b01;
  localparam logic [1:0] DR_D1   = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

endpackage

// File: rtl/dr_decode.sv
// rtl/dr_decode.sv - combinational dual-rail sum decoder: binary value, completeness and illegal-code flags
module dr_decode
  import ncl_ctl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] sum_dr,
  output logic [WIDTH-1:0]   value,
  output logic               complete,
  output logic               illegal
);

  always_comb begin
    value    = '0;
    complete = 1'b1;
    illegal  = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      value[k] = sum_dr[2*k+1];
      if (sum_dr[2*k +: 2] == DR_NULL || sum_dr[2*k +: 2] == DR_ILL) complete = 1'b0;
      if (sum_dr[2*k +: 2] == DR_ILL) illegal = 1'b1;
    end
  end

endmodule

// File: rtl/digit_counter_ctl.sv
// rtl/digit_counter_ctl.sv - burst controller driving DATA/NULL wavefronts into a dual-rail NCL counter
// Optional phase watchdog enabled by defining DIGIT_COUNTER_CTL_WATCHDOG_EN.
module digit_counter_ctl
  import ncl_ctl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               start,
  input  logic [31:0]        target,
  input  logic               abort,
  output logic [1:0]         cin,
  input  logic               ack,
  input  logic [2*WIDTH-1:0] sum_dr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        issued,
  output logic [WIDTH-1:0]   value,
  output logic               value_valid
);

  ctl_state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [WIDTH-1:0]       dec_value;
  logic                   dec_complete, dec_illegal;
  logic [31:0]            target_q;
  logic [32:0]            issued_p1;
  logic                   accept, clr_burst, inc_issued, latch_value;
  logic                   set_err, clr_err, phase_active;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) ack_sync <= '0;
    else         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  dr_decode #(.WIDTH(WIDTH)) u_decode (
    .sum_dr   (sum_dr),
    .value    (dec_value),
    .complete (dec_complete),
    .illegal  (dec_illegal)
  );

  assign issued_p1    = {1'b0, issued} + 33'd1;
  assign phase_active = (state_q == WAIT_RFD) || (state_q == DATA) ||
                        (state_q == NULL) || (state_q == DRAIN);

`ifdef DIGIT_COUNTER_CTL_WATCHDOG_EN
  localparam int PW = $clog2(TIMEOUT + 1);
  logic [PW-1:0] phase_cnt;

  // Counts cycles spent in the current state; restarts on every transition.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)                      phase_cnt <= '0;
    else if (state_d != state_q)      phase_cnt <= '0;
    else if (phase_cnt != PW'(TIMEOUT)) phase_cnt <= phase_cnt + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    clr_burst   = 1'b0;
    inc_issued  = 1'b0;
    latch_value = 1'b0;
    set_err     = 1'b0;
    clr_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          accept = 1'b1;
          if (target == 32'd0) begin
            state_d = DONE;
          end else begin
            clr_burst = 1'b1;
            state_d   = WAIT_RFD;
          end
        end
      end
      WAIT_RFD: begin
        if (abort)      state_d = DRAIN;
        else if (ack_s) state_d = DATA;
      end
      DATA: begin
        latch_value = dec_complete;
        if (abort)       state_d = DRAIN;
        else if (!ack_s) state_d = NULL;
      end
      NULL: begin
        if (abort) begin
          state_d = DRAIN;
        end else if (ack_s) begin
          inc_issued = 1'b1;
          state_d    = (issued_p1 == {1'b0, target_q}) ? DONE : DATA;
        end
      end
      DRAIN: if (ack_s) state_d = IDLE;
      DONE:  state_d = IDLE;
      ERR: begin
        if (abort) begin
          clr_err = 1'b1;
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    // An illegal digit overrides every other decision while a phase is active.
    if (phase_active && dec_illegal) begin
      set_err = 1'b1;
      state_d = ERR;
    end
`ifdef DIGIT_COUNTER_CTL_WATCHDOG_EN
    if (phase_active && phase_cnt == PW'(TIMEOUT - 1)) begin
      set_err = 1'b1;
      state_d = ERR;
    end
`endif
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= IDLE;
      cin         <= DR_NULL;
      err         <= 1'b0;
      issued      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      target_q    <= '0;
    end else begin
      state_q <= state_d;
      cin     <= (state_d == DATA) ? DR_D1 : DR_NULL;
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (accept) target_q <= target;
      if (clr_burst) begin
        issued      <= '0;
        value_valid <= 1'b0;
      end else begin
        if (inc_issued && !issued_p1[32]) issued <= issued_p1[31:0];
        if (latch_value) begin
          value       <= dec_value;
          value_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_digit_counter_ctl.sv
// tb/tb_digit_counter_ctl.sv - directed self-checking bench for digit_counter_ctl
module tb_digit_counter_ctl;

  localparam int WIDTH = 32;

  logic               clk    = 1'b0;
  logic               init_n = 1'b0;
  logic               start  = 1'b0;
  logic               abort  = 1'b0;
  logic               ack    = 1'b1;
  logic [31:0]        target = '0;
  logic [2*WIDTH-1:0] sum_dr = '0;
  logic [1:0]         cin;
  logic               busy, done, err, value_valid;
  logic [31:0]        issued;
  logic [WIDTH-1:0]   value;

  int checks = 0;
  int errors = 0;

  logic [1:0]  m_last_cin;
  int          m_dly;
  logic [31:0] m_count;
  int          m_waves;

  always #5 clk = ~clk;

  digit_counter_ctl #(.WIDTH(WIDTH), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk         (clk),
    .init_n      (init_n),
    .start       (start),
    .target      (target),
    .abort       (abort),
    .cin         (cin),
    .ack         (ack),
    .sum_dr      (sum_dr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .issued      (issued),
    .value       (value),
    .value_valid (value_valid)
  );

  function automatic logic [2*WIDTH-1:0] enc(input logic [31:0] v);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < WIDTH; k++) r[2*k +: 2] = v[k] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic model_reset();
    m_last_cin = 2'b00;
    m_dly      = 0;
    m_count    = '0;
    m_waves    = 0;
    ack        = 1'b1;
    sum_dr     = '0;
  endtask

  // Behavioural counter: responds 3 cycles after each cin change.
  task automatic model_step();
    if (cin !== m_last_cin) begin
      m_last_cin = cin;
      m_dly      = 3;
      if (cin === 2'b10) m_waves++;
    end else if (m_dly > 0) begin
      m_dly--;
      if (m_dly == 0) begin
        if (m_last_cin === 2'b10) begin
          m_count++;
          sum_dr = enc(m_count);
          ack    = 1'b0;
        end else begin
          sum_dr = '0;
          ack    = 1'b1;
        end
      end
    end
  endtask

  task automatic start_burst(input logic [31:0] t);
    @(negedge clk);
    start  = 1'b1;
    target = t;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic run_to_idle(input int max_cyc, output int dcnt, output bit ok);
    dcnt = 0;
    ok   = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      model_step();
      if (done) dcnt++;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (cin !== 2'b00)   begin errors++; $display("FAIL reset_cin: got %b expected 00", cin); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (issued !== 32'd0) begin errors++; $display("FAIL reset_issued: got %0d expected 0", issued); end
    checks++; if (value !== '0)    begin errors++; $display("FAIL reset_value: got %0h expected 0", value); end
    checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_value_valid: got %b expected 0", value_valid); end
    init_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero_target();
    start_burst(32'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++; if (cin !== 2'b00) begin errors++; $display("FAIL zero_cin: got %b expected 00", cin); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
    checks++; if (issued !== 32'd0) begin errors++; $display("FAIL zero_issued: got %0d expected 0", issued); end
    checks++; if (cin !== 2'b00) begin errors++; $display("FAIL zero_cin_after: got %b expected 00", cin); end
  endtask

  task automatic test_burst5();
    int dcnt;
    bit ok;
    model_reset();
    start_burst(32'd5);
    run_to_idle(1000, dcnt, ok);
    checks++; if (ok !== 1'b1)      begin errors++; $display("FAIL burst5_timeout: got %b expected 1", ok); end
    checks++; if (m_waves != 5)     begin errors++; $display("FAIL burst5_waves: got %0d expected 5", m_waves); end
    checks++; if (issued !== 32'd5) begin errors++; $display("FAIL burst5_issued: got %0d expected 5", issued); end
    checks++; if (dcnt != 1)        begin errors++; $display("FAIL burst5_done_count: got %0d expected 1", dcnt); end
    checks++; if (value !== 32'd5)  begin errors++; $display("FAIL burst5_value: got %0d expected 5", value); end
    checks++; if (value_valid !== 1'b1) begin errors++; $display("FAIL burst5_value_valid: got %b expected 1", value_valid); end
    checks++; if (cin !== 2'b00)    begin errors++; $display("FAIL burst5_cin_idle: got %b expected 00", cin); end
  endtask

  task automatic test_abort();
    int  dcnt = 0;
    int  drain = 0;
    int  cd = 0;
    bit  armed = 1'b0;
    bit  aborted = 1'b0;
    bit  ok = 1'b0;
    model_reset();
    start_burst(32'd10);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (abort) begin
        abort   = 1'b0;
        aborted = 1'b1;
        checks++; if (cin !== 2'b00) begin errors++; $display("FAIL abort_cin: got %b expected 00", cin); end
      end
      model_step();
      if (done) dcnt++;
      if (aborted && busy) drain++;
      if (!busy) begin ok = 1'b1; break; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) abort = 1'b1;
      end
      if (!armed && m_waves == 3 && ack === 1'b0) begin
        armed = 1'b1;
        cd    = 2;
      end
    end
    checks++; if (!(ok && aborted)) begin errors++; $display("FAIL abort_timeout: got ok=%b aborted=%b expected 1 1", ok, aborted); end
    checks++; if (drain != 6)       begin errors++; $display("FAIL abort_drain_cycles: got %0d expected 6", drain); end
    checks++; if (dcnt != 0)        begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dcnt); end
    checks++; if (issued !== 32'd2) begin errors++; $display("FAIL abort_issued: got %0d expected 2", issued); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL abort_err: got %b expected 0", err); end
  endtask

  task automatic test_illegal();
    bit found = 1'b0;
    model_reset();
    start_burst(32'd3);
    for (int i = 0; i < 50; i++) begin
      if (cin === 2'b10) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL illegal_reach_data: got %b expected 1", found); end
    sum_dr = enc(32'd1);
    sum_dr[15:14] = 2'b11;
    @(negedge clk);
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL illegal_err: got %b expected 1", err); end
    checks++; if (cin !== 2'b00) begin errors++; $display("FAIL illegal_cin: got %b expected 00", cin); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL illegal_err_sticky: got %b expected 1", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL illegal_busy: got %b expected 1", busy); end
    abort  = 1'b1;
    sum_dr = '0;
    @(negedge clk);
    abort  = 1'b0;
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL illegal_abort_clears: got %b expected 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL illegal_drain_busy: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_idle: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL illegal_no_done: got %b expected 0", done); end
  endtask

  task automatic test_watchdog();
    bit found = 1'b0;
    model_reset();
    start_burst(32'd1);
    for (int i = 0; i < 50; i++) begin
      if (cin === 2'b10) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL wdog_reach_data: got %b expected 1", found); end
`ifdef DIGIT_COUNTER_CTL_WATCHDOG_EN
    repeat (15) @(negedge clk);
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL wdog_early: got %b expected 0", err); end
    @(negedge clk);
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL wdog_err: got %b expected 1", err); end
    checks++; if (cin !== 2'b00) begin errors++; $display("FAIL wdog_cin: got %b expected 00", cin); end
`else
    repeat (1000) @(negedge clk);
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL nowdog_err: got %b expected 0", err); end
    checks++; if (cin !== 2'b10) begin errors++; $display("FAIL nowdog_cin: got %b expected 10", cin); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nowdog_busy: got %b expected 1", busy); end
`endif
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wdog_exit_idle: got %b expected 0", busy); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL wdog_exit_err: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid_burst();
    int  dcnt;
    bit  ok;
    bit  found = 1'b0;
    model_reset();
    start_burst(32'd10);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      model_step();
      if (issued === 32'd3) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach3: got %b expected 1", found); end
    #2 init_n = 1'b0;
    #1;
    checks++; if (cin !== 2'b00)    begin errors++; $display("FAIL midrst_cin: got %b expected 00", cin); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (issued !== 32'd0) begin errors++; $display("FAIL midrst_issued: got %0d expected 0", issued); end
    checks++; if (value !== '0)     begin errors++; $display("FAIL midrst_value: got %0h expected 0", value); end
    checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL midrst_value_valid: got %b expected 0", value_valid); end
    checks++; if (err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_err_done: got %b%b expected 00", err, done); end
    @(negedge clk);
    init_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    start_burst(32'd2);
    run_to_idle(1000, dcnt, ok);
    checks++; if (ok !== 1'b1)      begin errors++; $display("FAIL midrst_rerun_timeout: got %b expected 1", ok); end
    checks++; if (issued !== 32'd2) begin errors++; $display("FAIL midrst_rerun_issued: got %0d expected 2", issued); end
    checks++; if (dcnt != 1)        begin errors++; $display("FAIL midrst_rerun_done: got %0d expected 1", dcnt); end
    checks++; if (value !== 32'd2)  begin errors++; $display("FAIL midrst_rerun_value: got %0d expected 2", value); end
  endtask

  initial begin
    test_reset();
    test_zero_target();
    test_burst5();
    test_abort();
    test_illegal();
    test_watchdog();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
